// File: rtl/wb_stage.sv
// wb_stage: writeback stage of the 32-bit RISC-V core.
// Holds the MEM/WB pipeline register, extracts and extends load data,
// selects the writeback source, drives the register-file write port and
// the forwarding bus, flags misaligned loads and counts retired instructions.
module wb_stage #(
    parameter int XLEN      = 32,
    parameter int RET_CNT_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_in,
    input  logic                 flush_in,
    input  logic                 valid_in,
    input  logic [XLEN-1:0]      alu_result_in,
    input  logic [XLEN-1:0]      load_data_in,
    input  logic [XLEN-1:0]      pc_plus4_in,
    input  logic [2:0]           funct3_in,
    input  logic [1:0]           wb_sel_in,
    input  logic                 mem_read_in,
    input  logic [4:0]           rd_addr_in,
    input  logic                 reg_write_in,
    output logic                 rf_wr_en,
    output logic [4:0]           rf_wr_addr,
    output logic [XLEN-1:0]      rf_wr_data,
    output logic                 fwd_valid,
    output logic [4:0]           fwd_rd,
    output logic [XLEN-1:0]      fwd_data,
    output logic                 load_misalign,
    output logic [XLEN-1:0]      misalign_addr,
    output logic [RET_CNT_W-1:0] instret
);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;

    localparam int NUM_BYTES = XLEN / 8;
    localparam int NUM_HALVES = XLEN / 16;

    // MEM/WB register contents
    logic            valid_q;
    logic            done_q;      // instruction already retired while held by a stall
    logic [XLEN-1:0] alu_q;
    logic [XLEN-1:0] load_q;
    logic [XLEN-1:0] pc4_q;
    logic [2:0]      funct3_q;
    logic [1:0]      wb_sel_q;
    logic            mem_read_q;
    logic [4:0]      rd_q;
    logic            reg_write_q;

    // Registered reporting state
    logic                 load_misalign_reg;
    logic [XLEN-1:0]      misalign_addr_reg;
    logic [RET_CNT_W-1:0] instret_reg;

    // Combinational helpers
    logic [1:0]      off;
    logic [XLEN-1:0] load_ext;
    logic [XLEN-1:0] wb_data;
    logic            mis;
    logic            retire_evt;
    logic            writes_rd;

    logic [7:0]  byte_lane [NUM_BYTES];
    logic [15:0] half_lane [NUM_HALVES];

    // MEM/WB register: flush beats stall, stall holds fields and marks retirement
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            alu_q       <= '0;
            load_q      <= '0;
            pc4_q       <= '0;
            funct3_q    <= '0;
            wb_sel_q    <= '0;
            mem_read_q  <= 1'b0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
        end else if (flush_in) begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else if (stall_in) begin
            done_q <= done_q | valid_q;
        end else begin
            valid_q     <= valid_in;
            done_q      <= 1'b0;
            alu_q       <= alu_result_in;
            load_q      <= load_data_in;
            pc4_q       <= pc_plus4_in;
            funct3_q    <= funct3_in;
            wb_sel_q    <= wb_sel_in;
            mem_read_q  <= mem_read_in;
            rd_q        <= rd_addr_in;
            reg_write_q <= reg_write_in;
        end
    end

    // Split the raw memory word into byte and halfword lanes
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BYTES; gi++) begin : g_byte_lane
            assign byte_lane[gi] = load_q[8*gi +: 8];
        end
        for (gi = 0; gi < NUM_HALVES; gi++) begin : g_half_lane
            assign half_lane[gi] = load_q[16*gi +: 16];
        end
    endgenerate

    assign off = alu_q[1:0];

    // Select the addressed lane and sign- or zero-extend it
    always_comb begin
        load_ext = '0;
        case (funct3_q)
            F3_LB:  load_ext = {{(XLEN-8){byte_lane[off][7]}}, byte_lane[off]};
            F3_LBU: load_ext = {{(XLEN-8){1'b0}}, byte_lane[off]};
            F3_LH:  load_ext = {{(XLEN-16){half_lane[off[1]][15]}}, half_lane[off[1]]};
            F3_LHU: load_ext = {{(XLEN-16){1'b0}}, half_lane[off[1]]};
            F3_LW:  load_ext = load_q;
            default: load_ext = '0;
        endcase
    end

    // Misalignment check: halfwords need even addresses, words need word alignment
    always_comb begin
        mis = 1'b0;
        if (mem_read_q) begin
            if ((funct3_q == F3_LH || funct3_q == F3_LHU) && off[0])
                mis = 1'b1;
            else if (funct3_q == F3_LW && off != 2'b00)
                mis = 1'b1;
        end
    end

    // Writeback source mux; the reserved code falls back to the ALU result
    always_comb begin
        case (wb_sel_q)
            SEL_LOAD: wb_data = load_ext;
            SEL_PC4:  wb_data = pc4_q;
            default:  wb_data = alu_q;
        endcase
    end

    assign retire_evt = valid_q & ~done_q;
    assign writes_rd  = valid_q & reg_write_q & (rd_q != 5'd0) & ~mis;

    // The write port fires once; forwarding stays up while the instruction is held
    assign rf_wr_en   = writes_rd & ~done_q;
    assign rf_wr_addr = rd_q;
    assign rf_wr_data = wb_data;
    assign fwd_valid  = writes_rd;
    assign fwd_rd     = rd_q;
    assign fwd_data   = wb_data;

    // Misaligned-load pulse, sticky fault address, and retired-instruction count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_misalign_reg <= 1'b0;
            misalign_addr_reg <= '0;
            instret_reg       <= '0;
        end else begin
            load_misalign_reg <= retire_evt & mis;
            if (retire_evt & mis)
                misalign_addr_reg <= alu_q;
            if (retire_evt & ~mis)
                instret_reg <= instret_reg + RET_CNT_W'(1);
        end
    end

    assign load_misalign = load_misalign_reg;
    assign misalign_addr = misalign_addr_reg;
    assign instret       = instret_reg;

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed and randomized checks of wb_stage against a
// behavioural model of the instruction sitting in the writeback slot.
`timescale 1ns/1ps
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_in, flush_in, valid_in;
    logic [31:0] alu_result_in, load_data_in, pc_plus4_in;
    logic [2:0]  funct3_in;
    logic [1:0]  wb_sel_in;
    logic        mem_read_in;
    logic [4:0]  rd_addr_in;
    logic        reg_write_in;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        load_misalign;
    logic [31:0] misalign_addr;
    logic [63:0] instret;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .rst(rst),
        .stall_in(stall_in), .flush_in(flush_in), .valid_in(valid_in),
        .alu_result_in(alu_result_in), .load_data_in(load_data_in),
        .pc_plus4_in(pc_plus4_in), .funct3_in(funct3_in), .wb_sel_in(wb_sel_in),
        .mem_read_in(mem_read_in), .rd_addr_in(rd_addr_in), .reg_write_in(reg_write_in),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .load_misalign(load_misalign), .misalign_addr(misalign_addr), .instret(instret)
    );

    // Model of the instruction in the writeback slot
    typedef struct {
        logic        valid;
        logic        retired;
        logic [31:0] addr;
        logic [31:0] word;
        logic [31:0] pc4;
        logic [2:0]  f3;
        logic [1:0]  sel;
        logic        is_load;
        logic [4:0]  rd;
        logic        writes;
    } slot_t;

    slot_t       m;
    logic        m_pulse;
    logic [31:0] m_fault;
    logic [63:0] m_count;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic m_mis();
        int a;
        a = int'(m.addr % 4);
        if (!m.is_load) return 1'b0;
        if ((m.f3 == 3'd1 || m.f3 == 3'd5) && (a % 2 != 0)) return 1'b1;
        if (m.f3 == 3'd2 && a != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_load_value();
        int          a;
        logic [31:0] shifted;
        a = int'(m.addr % 4);
        shifted = m.word >> (8 * a);
        case (m.f3)
            3'd0: return (shifted[7] ? 32'hFFFF_FF00 : 32'h0) | (shifted & 32'hFF);
            3'd4: return shifted & 32'hFF;
            3'd1: begin
                shifted = m.word >> (16 * (a / 2));
                return (shifted[15] ? 32'hFFFF_0000 : 32'h0) | (shifted & 32'hFFFF);
            end
            3'd5: return (m.word >> (16 * (a / 2))) & 32'hFFFF;
            3'd2: return m.word;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_wb();
        if (m.sel == 2'd1) return m_load_value();
        if (m.sel == 2'd2) return m.pc4;
        return m.addr;
    endfunction

    task automatic model_reset();
        m = '{default: '0};
        m_pulse = 1'b0;
        m_fault = '0;
        m_count = '0;
    endtask

    // Advance the model by one clock edge using the inputs the DUT just sampled
    task automatic model_edge();
        logic retiring, bad;
        retiring = m.valid && !m.retired;
        bad = m_mis();
        m_pulse = retiring && bad;
        if (retiring && bad) m_fault = m.addr;
        if (retiring && !bad) m_count = m_count + 1;
        if (flush_in) begin
            m.valid = 1'b0;
            m.retired = 1'b0;
        end else if (stall_in) begin
            if (m.valid) m.retired = 1'b1;
        end else begin
            m.valid = valid_in;   m.retired = 1'b0;
            m.addr = alu_result_in; m.word = load_data_in; m.pc4 = pc_plus4_in;
            m.f3 = funct3_in;     m.sel = wb_sel_in;   m.is_load = mem_read_in;
            m.rd = rd_addr_in;    m.writes = reg_write_in;
        end
    endtask

    task automatic check_outputs();
        logic fwd;
        fwd = m.valid && m.writes && (m.rd != 0) && !m_mis();
        check("rf_wr_en",      rf_wr_en,      fwd && !m.retired);
        check("rf_wr_addr",    rf_wr_addr,    m.rd);
        check("rf_wr_data",    rf_wr_data,    m_wb());
        check("fwd_valid",     fwd_valid,     fwd);
        check("fwd_rd",        fwd_rd,        m.rd);
        check("fwd_data",      fwd_data,      m_wb());
        check("load_misalign", load_misalign, m_pulse);
        check("misalign_addr", misalign_addr, m_fault);
        check("instret",       instret,       m_count);
    endtask

    // One clock: DUT and model take the edge, outputs are compared on the falling edge
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic set_instr(input logic v, input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] p, input logic [2:0] f, input logic [1:0] s,
                             input logic mr, input logic [4:0] r, input logic rw);
        valid_in = v; alu_result_in = a; load_data_in = d; pc_plus4_in = p;
        funct3_in = f; wb_sel_in = s; mem_read_in = mr; rd_addr_in = r; reg_write_in = rw;
    endtask

    int en_cnt, fwd_cnt;
    logic [63:0] base;

    initial begin
        rst = 1'b1; stall_in = 1'b0; flush_in = 1'b0;
        set_instr(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 32'h44, 3'd2, 2'd1, 1'b1, 5'd9, 1'b1);
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();                       // outputs zero while in reset
        set_instr(1'b0, 0, 0, 0, 3'd0, 2'd0, 1'b0, 5'd0, 1'b0);
        rst = 1'b0;
        #1 check_outputs();                    // still zero before the first edge

        // LB from byte 3 with sign extension
        set_instr(1'b1, 32'h1003, 32'h80FF_1234, 32'h0, 3'd0, 2'd1, 1'b1, 5'd5, 1'b1);
        step();
        check("lb_en",   rf_wr_en,   1'b1);
        check("lb_addr", rf_wr_addr, 5'd5);
        check("lb_data", rf_wr_data, 32'hFFFF_FF80);

        // LHU then LH of the upper half
        set_instr(1'b1, 32'h2002, 32'hBEEF_0000, 32'h0, 3'd5, 2'd1, 1'b1, 5'd7, 1'b1);
        step();
        check("lb_instret", instret, 64'd1);
        check("lhu_data", rf_wr_data, 32'h0000_BEEF);
        funct3_in = 3'd1;
        step();
        check("lh_data", rf_wr_data, 32'hFFFF_BEEF);

        // ALU result to x0, then JAL writing PC+4 to x1
        set_instr(1'b1, 32'h1234, 32'h0, 32'h0, 3'd0, 2'd0, 1'b0, 5'd0, 1'b1);
        step();
        check("x0_en",  rf_wr_en,  1'b0);
        check("x0_fwd", fwd_valid, 1'b0);
        base = instret;
        set_instr(1'b1, 32'h0, 32'h0, 32'h104, 3'd0, 2'd2, 1'b0, 5'd1, 1'b1);
        step();
        check("x0_instret", instret, base + 1);
        check("jal_en",   rf_wr_en,   1'b1);
        check("jal_addr", rf_wr_addr, 5'd1);
        check("jal_data", rf_wr_data, 32'h104);

        // Stall holding one instruction for three extra cycles
        set_instr(1'b1, 32'h55AA, 32'h0, 32'h0, 3'd0, 2'd0, 1'b0, 5'd12, 1'b1);
        step();
        base = instret;
        en_cnt = int'(rf_wr_en); fwd_cnt = int'(fwd_valid);
        valid_in = 1'b0; stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            en_cnt += int'(rf_wr_en); fwd_cnt += int'(fwd_valid);
        end
        check("stall_en_cycles",  en_cnt,  1);
        check("stall_fwd_cycles", fwd_cnt, 4);
        check("stall_instret",    instret, base + 1);
        stall_in = 1'b0;

        // Misaligned LW: no write, one-cycle pulse, then stall+flush gives a bubble
        set_instr(1'b1, 32'h1002, 32'hCAFE_F00D, 32'h0, 3'd2, 2'd1, 1'b1, 5'd3, 1'b1);
        step();
        check("lw_mis_en", rf_wr_en, 1'b0);
        base = instret;
        stall_in = 1'b1; flush_in = 1'b1;
        step();
        check("lw_mis_pulse",   load_misalign, 1'b1);
        check("lw_mis_addr",    misalign_addr, 32'h1002);
        check("lw_mis_instret", instret,       base);
        check("flush_bubble",   fwd_valid,     1'b0);
        stall_in = 1'b0; flush_in = 1'b0; valid_in = 1'b0;
        step();
        check("lw_pulse_end", load_misalign, 1'b0);

        // Asynchronous reset while an instruction is held
        set_instr(1'b1, 32'h77, 32'h0, 32'h0, 3'd0, 2'd0, 1'b0, 5'd20, 1'b1);
        step();
        #1 rst = 1'b1;
        #1 model_reset();
        check("rst_en",      rf_wr_en,  1'b0);
        check("rst_fwd",     fwd_valid, 1'b0);
        check("rst_instret", instret,   64'd0);
        #1 rst = 1'b0;
        step();
        check("post_rst_en",   rf_wr_en,   1'b1);
        check("post_rst_data", rf_wr_data, 32'h77);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [2:0] f3s [7];
            f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd7};
            stall_in      = ($urandom_range(0, 3) == 0);
            flush_in      = ($urandom_range(0, 9) == 0);
            valid_in      = ($urandom_range(0, 4) != 0);
            alu_result_in = $urandom;
            load_data_in  = $urandom;
            pc_plus4_in   = $urandom;
            funct3_in     = f3s[$urandom_range(0, 6)];
            wb_sel_in     = 2'($urandom_range(0, 3));
            mem_read_in   = (wb_sel_in == 2'd1) ? 1'b1 : 1'($urandom_range(0, 1));
            rd_addr_in    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            reg_write_in  = ($urandom_range(0, 5) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Final pipeline stage of the 32-bit RISC-V core, directly downstream of the memory-access stage.
- Contains the MEM/WB pipeline register.
- Extracts and extends the loaded byte or halfword from the raw memory word, selects the writeback source, and drives the register-file write port and the forwarding bus.
- Detects misaligned loads and keeps a 64-bit retired-instruction counter.

Parameters:
XLEN, 32, datapath width
RET_CNT_W, 64, retired-instruction counter width

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous, active-high reset
stall_in  input  1  hold the MEM/WB register contents
flush_in  input  1  load a bubble into the MEM/WB register
valid_in  input  1  incoming instruction is valid
alu_result_in  input  XLEN  ALU result / memory address
load_data_in  input  XLEN  raw, unaligned word read from data memory
pc_plus4_in  input  XLEN  PC+4 for JAL/JALR
funct3_in  input  3  load type (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
wb_sel_in  input  2  writeback source: 00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU)
mem_read_in  input  1  instruction is a load
rd_addr_in  input  5  destination register
reg_write_in  input  1  instruction writes rd
rf_wr_en  output  1  register-file write enable
rf_wr_addr  output  5  register-file write address
rf_wr_data  output  XLEN  register-file write data
fwd_valid  output  1  forwarding bus valid
fwd_rd  output  5  forwarding register
fwd_data  output  XLEN  forwarding data
load_misalign  output  1  misaligned-load pulse
misalign_addr  output  XLEN  faulting address
instret  output  RET_CNT_W  retired-instruction count

Behaviour:
- Reset (async, rst=1): clears valid_q, done_q, all captured fields, instret, load_misalign and misalign_addr. All outputs read 0 while rst is high and on the first clock after release.
- Register update, per rising edge:
  - flush_in=1: valid_q<=0 and done_q<=0. Flush takes priority over stall.
  - else stall_in=1: all captured fields hold, and done_q<=done_q|valid_q.
  - else: capture every *_in field, set valid_q<=valid_in, clear done_q.
- Latency: an instruction presented at edge N drives rf_wr_en in the cycle after edge N.
- Load extraction (combinational on registered fields), off = addr_q[1:0]:
  - LB/LBU: byte off, sign- or zero-extended.
  - LH/LHU: half off[1], sign- or zero-extended.
  - LW: whole word.
  - Any other funct3: 0.
- Misalignment: mis = mem_read_q & ((LH/LHU & off[0]) | (LW & off!=0)).
- Writeback data:
  - wb_sel_q=01 → extracted load data.
  - wb_sel_q=10 → pc_plus4_q.
  - otherwise → alu_q.
- Writes fire exactly once per instruction, even while stalled:
  - rf_wr_en = valid_q & ~done_q & reg_write_q & (rd_q!=0) & ~mis.
  - rf_wr_addr = rd_q; rf_wr_data = writeback data.
  - Writes to x0 are always suppressed.
- Forwarding bus stays valid for as long as the instruction is held:
  - fwd_valid = valid_q & reg_write_q & (rd_q!=0) & ~mis.
  - fwd_rd = rd_q; fwd_data = writeback data.
- Misaligned-load reporting (registered):
  - On the edge where retire_evt = valid_q & ~done_q holds with mis=1: load_misalign<=1 for exactly one cycle and misalign_addr<=alu_q.
  - misalign_addr holds until the next misaligned load.
- instret:
  - Increments on every edge where retire_evt & ~mis, including x0-destination and non-writing instructions.
  - Wraps from 2^RET_CNT_W-1 to 0.
  - Misaligned loads and bubbles are not counted.
- Simultaneous events:
  - flush while an instruction is held: that instruction is dropped. If it had not yet written, it never writes.
  - stall with valid_q=0: nothing happens.
  - reset mid-operation: all state clears immediately and asynchronously; no partial write.

Test Plan:
- LB, addr 0x1003, load_data 0x80FF1234, rd=5, wb_sel=01 → one cycle later rf_wr_en=1, addr 5, data 0xFFFFFF80; instret=1.
- LHU, addr 0x2002, load_data 0xBEEF0000, rd=7 → rf_wr_data 0x0000BEEF; LH of the same → 0xFFFFBEEF.
- ALU instr rd=0, alu 0x1234, then JAL rd=1, pc_plus4 0x104 → first: rf_wr_en=0, fwd_valid=0, instret+1; second: write 0x104 to x1.
- Instruction captured, then stall_in=1 for 3 cycles → rf_wr_en high exactly 1 cycle; fwd_valid high all 4 cycles; instret +1 only.
- LW, addr 0x1002, rd=3 → rf_wr_en=0, load_misalign pulses 1 cycle, misalign_addr=0x1002, instret unchanged; stall+flush in the same cycle → bubble, no write.
- rst asserted mid-stream with valid_q=1 → rf_wr_en, fwd_valid and instret read 0 immediately; the first instruction after release writes normally.
